// File: rtl/multi_channel_clock_generator_pkg.sv
// Shared definitions for the multi-channel programmable clock generator:
// default sizes, per-channel sequencing modes and the config legality check.
package multi_channel_clock_generator_pkg;

  localparam int unsigned NUM_CH_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT  = 10;

  // What a channel does with its counter in the current cycle.
  //   CH_HOLD  : disabled or idle, counter parked at the phase offset
  //   CH_RUN   : counting 0..P-1, no shadow transfer this cycle
  //   CH_APPLY : running and at the wrap with a pending shadow config
  typedef enum logic [1:0] {
    CH_HOLD  = 2'd0,
    CH_RUN   = 2'd1,
    CH_APPLY = 2'd2
  } ch_mode_e;

  // A config is usable when the period has room for both a high and a low
  // phase and the start value lies inside the period.
  function automatic logic cfg_legal(input logic [31:0] period,
                                     input logic [31:0] high,
                                     input logic [31:0] phase);
    return (period >= 32'd2) && (high >= 32'd1) &&
           (high < period) && (phase < period);
  endfunction

endpackage

// File: rtl/multi_channel_clock_generator_channel.sv
// One output channel: period counter, active and shadow configuration,
// glitch-free shadow transfer at period boundaries, registered outputs.
module multi_channel_clock_generator_channel
  import multi_channel_clock_generator_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
)(
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             SYNC,
  input  logic             CFG_WE,
  input  logic [CNT_W-1:0] CFG_PERIOD,
  input  logic [CNT_W-1:0] CFG_HIGH,
  input  logic [CNT_W-1:0] CFG_PHASE,
  output logic             PENDING,
  output logic             CLK_OUT,
  output logic             CYCLE_START
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_p_q, act_h_q, act_f_q;
  logic [CNT_W-1:0] sh_p_q, sh_h_q, sh_f_q;
  logic             pending_q;
  logic             clk_q, start_q;
  logic             running, wrap, apply;
  ch_mode_e         mode;

  // Mode decode and counter next-state; SYNC and shadow apply share the path
  // so a SYNC landing on an apply cycle starts from the new phase offset.
  always_comb begin
    running = EN && (act_p_q != '0);
    wrap    = running && (cnt_q == (act_p_q - ONE));
    mode    = CH_RUN;
    apply   = 1'b0;
    cnt_d   = cnt_q;
    if (!running) begin
      mode = CH_HOLD;
    end else if (pending_q && wrap) begin
      mode = CH_APPLY;
    end
    case (mode)
      CH_HOLD: begin
        apply = pending_q;
        cnt_d = pending_q ? sh_f_q : act_f_q;
      end
      CH_APPLY: begin
        apply = 1'b1;
        cnt_d = SYNC ? sh_f_q : '0;
      end
      default: begin
        if (SYNC) begin
          cnt_d = act_f_q;
        end else if (wrap) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  // Shadow capture on an accepted write, shadow-to-active transfer on apply.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sh_p_q    <= '0;
      sh_h_q    <= '0;
      sh_f_q    <= '0;
      act_p_q   <= '0;
      act_h_q   <= '0;
      act_f_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (CFG_WE) begin
        sh_p_q    <= CFG_PERIOD;
        sh_h_q    <= CFG_HIGH;
        sh_f_q    <= CFG_PHASE;
        pending_q <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
      if (apply) begin
        act_p_q <= sh_p_q;
        act_h_q <= sh_h_q;
        act_f_q <= sh_f_q;
      end
    end
  end

  // Counter and registered outputs, one cycle behind the counter value.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clk_q   <= running && (cnt_q < act_h_q);
      start_q <= running && (cnt_q == '0);
    end
  end

  assign PENDING     = pending_q;
  assign CLK_OUT     = clk_q;
  assign CYCLE_START = start_q;

endmodule

// File: rtl/multi_channel_clock_generator.sv
// NUM_CH-channel programmable clock generator: config decode, handshake,
// legality check, error flag and per-channel generator instances.
module multi_channel_clock_generator
  import multi_channel_clock_generator_pkg::*;
#(
  parameter  int unsigned NUM_CH = NUM_CH_DEFAULT,
  parameter  int unsigned CNT_W  = CNT_W_DEFAULT,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic              CLK_IN,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] EN,
  input  logic              SYNC,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [CNT_W-1:0]  CFG_PERIOD,
  input  logic [CNT_W-1:0]  CFG_HIGH,
  input  logic [CNT_W-1:0]  CFG_PHASE,
  output logic              CFG_ERR,
  output logic [NUM_CH-1:0] CLK_OUT,
  output logic [NUM_CH-1:0] CYCLE_START
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ch_we;
  logic              ch_valid;
  logic              cfg_ok;
  logic              accept;

  // READY mux on the addressed channel, legality check and write decode.
  // A channel number beyond NUM_CH is accepted and flagged as illegal.
  always_comb begin
    ch_valid  = (32'(CFG_CH) < NUM_CH);
    CFG_READY = 1'b1;
    if (ch_valid) begin
      CFG_READY = !pending[CFG_CH];
    end
    accept = CFG_VALID && CFG_READY;
    cfg_ok = ch_valid &&
             cfg_legal(32'(CFG_PERIOD), 32'(CFG_HIGH), 32'(CFG_PHASE));
    ch_we  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (32'(CFG_CH) == c) begin
        ch_we[c] = accept && cfg_ok;
      end
    end
  end

  // One-cycle error pulse for an accepted but rejected write.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      CFG_ERR <= 1'b0;
    end else begin
      CFG_ERR <= accept && !cfg_ok;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    multi_channel_clock_generator_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .CLK_IN      (CLK_IN),
      .RST_N       (RST_N),
      .EN          (EN[c]),
      .SYNC        (SYNC),
      .CFG_WE      (ch_we[c]),
      .CFG_PERIOD  (CFG_PERIOD),
      .CFG_HIGH    (CFG_HIGH),
      .CFG_PHASE   (CFG_PHASE),
      .PENDING     (pending[c]),
      .CLK_OUT     (CLK_OUT[c]),
      .CYCLE_START (CYCLE_START[c])
    );
  end

endmodule

// File: tb/tb_multi_channel_clock_generator.sv
// Directed scoreboard bench for multi_channel_clock_generator.
module tb_multi_channel_clock_generator;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned CH_W   = 2;

  logic              CLK_IN = 1'b0;
  logic              RST_N;
  logic [NUM_CH-1:0] EN;
  logic              SYNC;
  logic              CFG_VALID;
  logic              CFG_READY;
  logic [CH_W-1:0]   CFG_CH;
  logic [CNT_W-1:0]  CFG_PERIOD;
  logic [CNT_W-1:0]  CFG_HIGH;
  logic [CNT_W-1:0]  CFG_PHASE;
  logic              CFG_ERR;
  logic [NUM_CH-1:0] CLK_OUT;
  logic [NUM_CH-1:0] CYCLE_START;

  multi_channel_clock_generator #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK_IN      (CLK_IN),
    .RST_N       (RST_N),
    .EN          (EN),
    .SYNC        (SYNC),
    .CFG_VALID   (CFG_VALID),
    .CFG_READY   (CFG_READY),
    .CFG_CH      (CFG_CH),
    .CFG_PERIOD  (CFG_PERIOD),
    .CFG_HIGH    (CFG_HIGH),
    .CFG_PHASE   (CFG_PHASE),
    .CFG_ERR     (CFG_ERR),
    .CLK_OUT     (CLK_OUT),
    .CYCLE_START (CYCLE_START)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] cs;
    bit                rdy_en;
    logic              rdy;
    string             tag;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  int ill_p[4] = '{1, 4, 5, 5};
  int ill_h[4] = '{1, 0, 5, 2};
  int ill_f[4] = '{0, 0, 0, 7};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic drive(input int ch, input int p, input int h, input int f);
    CFG_CH     = CH_W'(ch);
    CFG_PERIOD = CNT_W'(p);
    CFG_HIGH   = CNT_W'(h);
    CFG_PHASE  = CNT_W'(f);
    CFG_VALID  = 1'b1;
  endtask

  // Expected waveform of up to two channels sharing P/H, given the counter
  // value each channel holds when the first pushed sample is produced.
  task automatic push_run(input int ca, input int sa, input int cb, input int sbv,
                          input int p, input int h, input int n,
                          input bit rdy_en, input logic rdy, input string tag);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   c;
      e.mask = '0;
      e.clk  = '0;
      e.cs   = '0;
      c = (sa + k) % p;
      e.mask[ca] = 1'b1;
      e.clk[ca]  = (c < h);
      e.cs[ca]   = (c == 0);
      if (cb >= 0) begin
        c = (sbv + k) % p;
        e.mask[cb] = 1'b1;
        e.clk[cb]  = (c < h);
        e.cs[cb]   = (c == 0);
      end
      e.rdy_en = rdy_en;
      e.rdy    = rdy;
      e.tag    = tag;
      sb.push_back(e);
    end
  endtask

  task automatic push_const(input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] clk,
                            input logic [NUM_CH-1:0] cs, input int n,
                            input bit rdy_en, input logic rdy, input string tag);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.mask   = mask;
      e.clk    = clk;
      e.cs     = cs;
      e.rdy_en = rdy_en;
      e.rdy    = rdy;
      e.tag    = tag;
      sb.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    tick();
    e = sb.pop_front();
    check({e.tag, "_clk"}, 32'(CLK_OUT & e.mask), 32'(e.clk & e.mask));
    check({e.tag, "_cs"}, 32'(CYCLE_START & e.mask), 32'(e.cs & e.mask));
    if (e.rdy_en) check({e.tag, "_rdy"}, 32'(CFG_READY), 32'(e.rdy));
  endtask

  task automatic drain();
    while (sb.size() > 0) step();
  endtask

  task automatic wait_cs(input int ch, input int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!CYCLE_START[ch] && k < budget);
    check("wait_cycle_start", 32'(CYCLE_START[ch]), 32'd1);
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!CFG_READY && k < budget);
    check("wait_ready", 32'(CFG_READY), 32'd1);
  endtask

  initial begin
    RST_N      = 1'b0;
    EN         = '0;
    SYNC       = 1'b0;
    CFG_VALID  = 1'b0;
    CFG_CH     = '0;
    CFG_PERIOD = '0;
    CFG_HIGH   = '0;
    CFG_PHASE  = '0;
    #2;
    check("rst_clk", 32'(CLK_OUT), 32'd0);
    check("rst_cs", 32'(CYCLE_START), 32'd0);
    check("rst_err", 32'(CFG_ERR), 32'd0);
    check("rst_rdy", 32'(CFG_READY), 32'd1);
    @(negedge CLK_IN);
    RST_N = 1'b1;
    tick();

    // 1: ch0 P=4 H=2 F=0
    EN = 4'b0001;
    drive(0, 4, 2, 0);
    tick();
    check("t1_rdy_pending", 32'(CFG_READY), 32'd0);
    CFG_VALID = 1'b0;
    tick();
    check("t1_rdy_applied", 32'(CFG_READY), 32'd1);
    check("t1_clk_first", 32'(CLK_OUT[0]), 32'd0);
    push_run(0, 0, -1, 0, 4, 2, 12, 1'b1, 1'b1, "t1");
    drain();

    // 2: ch1 P=10 H=9 running, then P=6 H=3 written mid-period
    drive(1, 10, 9, 0);
    tick();
    CFG_VALID = 1'b0;
    tick();
    EN[1] = 1'b1;
    push_run(1, 0, -1, 0, 10, 9, 4, 1'b1, 1'b1, "t2_pre");
    drain();
    drive(1, 6, 3, 0);
    push_run(1, 4, -1, 0, 10, 9, 5, 1'b1, 1'b0, "t2_old");
    push_run(1, 9, -1, 0, 10, 9, 1, 1'b1, 1'b1, "t2_wrap");
    push_run(1, 0, -1, 0, 6, 3, 12, 1'b1, 1'b1, "t2_new");
    step();
    CFG_VALID = 1'b0;
    drain();

    // 3: illegal writes to running ch0
    for (int i = 0; i < 4; i++) begin
      drive(0, ill_p[i], ill_h[i], ill_f[i]);
      check("t3_rdy", 32'(CFG_READY), 32'd1);
      tick();
      check("t3_err_pulse", 32'(CFG_ERR), 32'd1);
      check("t3_no_pending", 32'(CFG_READY), 32'd1);
      CFG_VALID = 1'b0;
      tick();
      check("t3_err_clear", 32'(CFG_ERR), 32'd0);
    end
    wait_cs(0, 20);
    push_run(0, 1, -1, 0, 4, 2, 8, 1'b1, 1'b1, "t3_keep");
    drain();

    // 4: ch0 P=8 H=4 F=0, ch2 P=8 H=4 F=2, SYNC
    EN = 4'b0111;
    drive(0, 8, 4, 0);
    tick();
    check("t4_pending", 32'(CFG_READY), 32'd0);
    CFG_VALID = 1'b0;
    wait_ready(20);
    drive(2, 8, 4, 2);
    tick();
    CFG_VALID = 1'b0;
    tick();
    SYNC = 1'b1;
    tick();
    SYNC = 1'b0;
    push_run(0, 0, 2, 2, 8, 4, 16, 1'b1, 1'b1, "t4");
    drain();

    // 5: EN[0] dropped mid-high, then re-enabled
    CFG_CH = 2'd0;
    wait_cs(0, 20);
    check("t5_high", 32'(CLK_OUT[0]), 32'd1);
    EN[0] = 1'b0;
    push_const(4'b0001, 4'b0000, 4'b0000, 4, 1'b1, 1'b1, "t5_off");
    drain();
    EN[0] = 1'b1;
    push_run(0, 0, -1, 0, 8, 4, 8, 1'b1, 1'b1, "t5_resume");
    drain();

    // 6: asynchronous reset mid-period, then a write landing on a wrap
    wait_cs(0, 20);
    #3;
    RST_N = 1'b0;
    #1;
    check("t6_rst_clk", 32'(CLK_OUT), 32'd0);
    check("t6_rst_cs", 32'(CYCLE_START), 32'd0);
    check("t6_rst_err", 32'(CFG_ERR), 32'd0);
    check("t6_rst_rdy", 32'(CFG_READY), 32'd1);
    @(posedge CLK_IN);
    #3;
    RST_N = 1'b1;
    push_const(4'b1111, 4'b0000, 4'b0000, 4, 1'b1, 1'b1, "t6_idle");
    drain();
    drive(0, 4, 2, 0);
    tick();
    CFG_VALID = 1'b0;
    tick();
    push_run(0, 0, -1, 0, 4, 2, 3, 1'b1, 1'b1, "t6_a");
    drain();
    drive(0, 6, 3, 0);
    push_run(0, 3, -1, 0, 4, 2, 4, 1'b1, 1'b0, "t6_queued");
    push_run(0, 3, -1, 0, 4, 2, 1, 1'b1, 1'b1, "t6_wrap");
    push_run(0, 0, -1, 0, 6, 3, 12, 1'b1, 1'b1, "t6_new");
    step();
    CFG_VALID = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
